shared_port_arbiter: RTL and testbench

Two-requester round-robin arbiter that sequences the 16-bit 2-to-1 datapath mux (MUX16bit_2to1) feeding a shared write port in the single-cycle processor. It owns the mux select line, grants one requester at a time in bursts, and registers the selected word into a valid/ready output stage. Sits between two producer units (A, B) and the single consumer port.

---
 rtl/shared_port_arbiter.sv | 142 ++++++++++++++
 tb/tb_shared_port_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shared_port_arbiter.sv
// Two-requester round-robin burst arbiter that owns the select line of the
// shared write-port 2:1 mux and registers the chosen word into a valid/ready stage.
module shared_port_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int MAX_BURST  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_a,
  input  logic [DATA_WIDTH-1:0] data_a,
  input  logic                  last_a,
  input  logic                  req_b,
  input  logic [DATA_WIDTH-1:0] data_b,
  input  logic                  last_b,
  output logic                  gnt_a,
  output logic                  gnt_b,
  output logic                  mux_sel,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic                  busy
);

  // Handshakes: a producer word is consumed in any cycle where req_x && gnt_x;
  // gnt_x never depends on anything but state, req_x and the output stage having
  // room. The output word moves on when out_valid && out_ready; out_data and
  // out_last are stable while out_valid && !out_ready.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } state_t;

  localparam logic OWNER_A = 1'b0;
  localparam logic OWNER_B = 1'b1;

  state_t                state;
  logic                  last_owner;
  logic [3:0]            cnt;

  logic                  advance;
  logic                  transfer_a;
  logic                  transfer_b;
  logic                  cnt_hit;
  logic                  release_a;
  logic                  release_b;
  logic [DATA_WIDTH-1:0] mux_out;

  assign advance    = !out_valid || out_ready;
  assign transfer_a = (state == OWN_A) && req_a && advance;
  assign transfer_b = (state == OWN_B) && req_b && advance;
  assign gnt_a      = transfer_a;
  assign gnt_b      = transfer_b;
  assign busy       = (state != IDLE);

  // The word being transferred now is the last one of this ownership.
  assign cnt_hit   = (({1'b0, cnt} + 5'd1) == 5'(MAX_BURST));
  assign release_a = (transfer_a && (last_a || cnt_hit)) || !req_a;
  assign release_b = (transfer_b && (last_b || cnt_hit)) || !req_b;

  // The 2:1 datapath mux this block sequences.
  assign mux_out = mux_sel ? data_b : data_a;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_owner <= OWNER_B;
      cnt        <= 4'd0;
      mux_sel    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // On a tie the requester that did not own the port last time wins.
          if (req_a && (!req_b || (last_owner == OWNER_B))) begin
            state      <= OWN_A;
            cnt        <= 4'd0;
            mux_sel    <= 1'b0;
            last_owner <= OWNER_A;
          end else if (req_b) begin
            state      <= OWN_B;
            cnt        <= 4'd0;
            mux_sel    <= 1'b1;
            last_owner <= OWNER_B;
          end
        end
        OWN_A: begin
          if (release_a) begin
            if (req_b) begin
              state      <= OWN_B;
              cnt        <= 4'd0;
              mux_sel    <= 1'b1;
              last_owner <= OWNER_B;
            end else begin
              state <= IDLE;
            end
          end else if (transfer_a) begin
            cnt <= cnt + 4'd1;
          end
        end
        OWN_B: begin
          if (release_b) begin
            if (req_a) begin
              state      <= OWN_A;
              cnt        <= 4'd0;
              mux_sel    <= 1'b0;
              last_owner <= OWNER_A;
            end else begin
              state <= IDLE;
            end
          end else if (transfer_b) begin
            cnt <= cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output stage: refills whenever the consumer has taken (or never had) a word.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (advance) begin
      out_valid <= transfer_a || transfer_b;
      if (transfer_a || transfer_b) begin
        out_data <= mux_out;
      end
      if (transfer_a) begin
        out_last <= last_a || cnt_hit;
      end else if (transfer_b) begin
        out_last <= last_b || cnt_hit;
      end else begin
        out_last <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_shared_port_arbiter.sv
// Bench for shared_port_arbiter: directed scenarios with cycle-exact checks, then
// a randomized run scored against per-requester word queues and burst rules.
module tb_shared_port_arbiter;

  localparam int DW = 16;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_a, last_a, req_b, last_b;
  logic [DW-1:0] data_a, data_b;
  logic          gnt_a, gnt_b, mux_sel, out_valid, out_last, out_ready, busy;
  logic [DW-1:0] out_data;

  int vectors     = 0;
  int miscompares = 0;

  shared_port_arbiter #(.DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .data_a(data_a), .last_a(last_a),
    .req_b(req_b), .data_b(data_b), .last_b(last_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .mux_sel(mux_sel),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
    .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  // Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    req_a = 1'b0; req_b = 1'b0; last_a = 1'b0; last_b = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle_inputs();
    cyc(); cyc();
    rst = 1'b0; req_a = 1'b1; data_a = 16'(($urandom));
    cyc(); cyc(); cyc();
    smp();
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++; $display("FAIL reset_pre_busy got=%0b exp=1", busy);
    end
    rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    smp();
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid);
    end
    vectors++;
    if (out_data !== 16'h0000) begin
      miscompares++; $display("FAIL reset_out_data got=%h exp=0000", out_data);
    end
    vectors++;
    if (mux_sel !== 1'b0) begin
      miscompares++; $display("FAIL reset_mux_sel got=%0b exp=0", mux_sel);
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++; $display("FAIL reset_busy got=%0b exp=0", busy);
    end
    vectors++;
    if (gnt_a !== 1'b0 || gnt_b !== 1'b0) begin
      miscompares++; $display("FAIL reset_gnt got=%0b%0b exp=00", gnt_a, gnt_b);
    end
    req_a = 1'b0;
    cyc(); cyc();
  endtask

  // Tie from IDLE: A wins, runs MAX_BURST words, then B takes over with no gap.
  task automatic test_tie_limit();
    logic ea, eb, es, ev, el;
    logic [DW-1:0] ed;
    req_a = 1'b1; data_a = 16'hFFFF; last_a = 1'b0;
    req_b = 1'b1; data_b = 16'h0000; last_b = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      smp();
      ea = (c >= 1) && (c <= MB);
      eb = (c >= MB + 1);
      es = (c >= MB + 1);
      ev = (c >= 2);
      ed = (c <= MB + 1) ? 16'hFFFF : 16'h0000;
      el = (c == MB + 1);
      vectors++;
      if (gnt_a !== ea || gnt_b !== eb) begin
        miscompares++;
        $display("FAIL tie_gnt cycle=%0d got=%0b%0b exp=%0b%0b", c, gnt_a, gnt_b, ea, eb);
      end
      vectors++;
      if (mux_sel !== es) begin
        miscompares++; $display("FAIL tie_mux_sel cycle=%0d got=%0b exp=%0b", c, mux_sel, es);
      end
      vectors++;
      if (out_valid !== ev) begin
        miscompares++; $display("FAIL tie_out_valid cycle=%0d got=%0b exp=%0b", c, out_valid, ev);
      end
      if (c >= 2) begin
        vectors++;
        if (out_data !== ed || out_last !== el) begin
          miscompares++;
          $display("FAIL tie_out_word cycle=%0d got=%h/%0b exp=%h/%0b", c, out_data, out_last, ed, el);
        end
      end
      cyc();
    end
    idle_inputs();
    cyc(); cyc(); cyc();
  endtask

  // B sends two words ending with last_b, then immediately re-requests: one bubble.
  task automatic test_last_early();
    logic [DW-1:0] w0, w1, w2;
    w0 = 16'($urandom); w1 = 16'($urandom); w2 = 16'($urandom);
    req_b = 1'b1; data_b = w0; last_b = 1'b0;
    smp();
    vectors++;
    if (busy !== 1'b0 || gnt_b !== 1'b0) begin
      miscompares++; $display("FAIL early_c0 got=busy%0b/gnt%0b exp=0/0", busy, gnt_b);
    end
    cyc(); smp();
    vectors++;
    if (gnt_b !== 1'b1 || mux_sel !== 1'b1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL early_c1 got=gnt%0b/sel%0b/busy%0b exp=1/1/1", gnt_b, mux_sel, busy);
    end
    cyc(); data_b = w1; last_b = 1'b1; smp();
    vectors++;
    if (gnt_b !== 1'b1 || out_valid !== 1'b1 || out_data !== w0 || out_last !== 1'b0) begin
      miscompares++;
      $display("FAIL early_c2 got=gnt%0b/%0b/%h/%0b exp=1/1/%h/0", gnt_b, out_valid, out_data, out_last, w0);
    end
    cyc(); data_b = w2; last_b = 1'b1; smp();
    vectors++;
    if (busy !== 1'b0 || gnt_b !== 1'b0) begin
      miscompares++; $display("FAIL early_release got=busy%0b/gnt%0b exp=0/0", busy, gnt_b);
    end
    vectors++;
    if (out_valid !== 1'b1 || out_data !== w1 || out_last !== 1'b1) begin
      miscompares++;
      $display("FAIL early_last_word got=%0b/%h/%0b exp=1/%h/1", out_valid, out_data, out_last, w1);
    end
    cyc(); smp();
    vectors++;
    if (gnt_b !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++; $display("FAIL early_rearb got=gnt%0b/valid%0b exp=1/0", gnt_b, out_valid);
    end
    cyc(); req_b = 1'b0; last_b = 1'b0; smp();
    vectors++;
    if (out_valid !== 1'b1 || out_data !== w2 || out_last !== 1'b1) begin
      miscompares++;
      $display("FAIL early_third_word got=%0b/%h/%0b exp=1/%h/1", out_valid, out_data, out_last, w2);
    end
    cyc(); cyc();
  endtask

  // A streams while the consumer stalls for 3 cycles; scoreboard catches loss/dups.
  task automatic test_backpressure();
    logic [DW:0]   exp_q[$];
    logic [DW-1:0] base;
    int            sent;
    base = 16'($urandom);
    sent = 0;
    for (int c = 0; c < 18; c++) begin
      out_ready = !(c >= 3 && c <= 5);
      req_a     = (c < 12);
      data_a    = base + 16'(sent);
      last_a    = 1'b0;
      smp();
      if (c >= 3 && c <= 5) begin
        vectors++;
        if (out_valid !== 1'b1 || gnt_a !== 1'b0) begin
          miscompares++;
          $display("FAIL bp_stall cycle=%0d got=valid%0b/gnt%0b exp=1/0", c, out_valid, gnt_a);
        end
      end
      if (out_valid === 1'b1) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++; $display("FAIL bp_extra_word cycle=%0d got=%h exp=none", c, out_data);
        end else if ({out_last, out_data} !== exp_q[0]) begin
          miscompares++;
          $display("FAIL bp_word cycle=%0d got=%0b/%h exp=%0b/%h", c, out_last, out_data,
                   exp_q[0][DW], exp_q[0][DW-1:0]);
        end
        if (out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
      end
      if (gnt_a === 1'b1) begin
        exp_q.push_back({((sent % MB) == MB - 1), data_a});
        sent++;
      end
      cyc();
    end
    vectors++;
    if (exp_q.size() != 0 || sent < 6) begin
      miscompares++; $display("FAIL bp_drain got=left%0d/sent%0d exp=0/>=6", exp_q.size(), sent);
    end
    idle_inputs();
    cyc();
  endtask

  // A drops its request after one word; pending B is granted on the next edge.
  task automatic test_truncation();
    logic [DW-1:0] ta, tb;
    ta = 16'($urandom); tb = 16'($urandom);
    req_a = 1'b1; data_a = ta; last_a = 1'b0; out_ready = 1'b1;
    smp(); cyc();
    req_b = 1'b1; data_b = tb; last_b = 1'b0;
    smp();
    vectors++;
    if (gnt_a !== 1'b1 || gnt_b !== 1'b0) begin
      miscompares++; $display("FAIL trunc_c1 got=%0b%0b exp=10", gnt_a, gnt_b);
    end
    cyc(); req_a = 1'b0; smp();
    vectors++;
    if (gnt_a !== 1'b0 || gnt_b !== 1'b0 || out_valid !== 1'b1 || out_data !== ta || out_last !== 1'b0) begin
      miscompares++;
      $display("FAIL trunc_c2 got=%0b%0b/%0b/%h/%0b exp=00/1/%h/0", gnt_a, gnt_b, out_valid, out_data, out_last, ta);
    end
    cyc(); smp();
    vectors++;
    if (mux_sel !== 1'b1 || gnt_b !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL trunc_handoff got=sel%0b/gnt%0b/valid%0b exp=1/1/0", mux_sel, gnt_b, out_valid);
    end
    cyc(); req_b = 1'b0; smp();
    vectors++;
    if (out_valid !== 1'b1 || out_data !== tb || out_last !== 1'b0) begin
      miscompares++;
      $display("FAIL trunc_b_word got=%0b/%h/%0b exp=1/%h/0", out_valid, out_data, out_last, tb);
    end
    idle_inputs();
    cyc(); cyc(); cyc();
  endtask

  // Random bursts on both sides; data bit DW-1 tags the source requester.
  task automatic test_random();
    logic [DW:0] sa_q[$], sb_q[$], exp_a_q[$], exp_b_q[$];
    logic [DW:0] w;
    logic        src, run_src, must_valid, must_src, exp_last, done;
    int          len, run_k, cycles;
    for (int s = 0; s < 2; s++) begin
      for (int b = 0; b < 7; b++) begin
        len = $urandom_range(1, 7);
        for (int i = 0; i < len; i++) begin
          w = {(i == len - 1), s[0], 15'($urandom)};
          if (s == 0) begin sa_q.push_back(w); exp_a_q.push_back(w); end
          else        begin sb_q.push_back(w); exp_b_q.push_back(w); end
        end
      end
    end
    run_src = 1'b0; run_k = 0; must_valid = 1'b0; must_src = 1'b0;
    done = 1'b0; cycles = 0;
    while (!done && cycles < 4000) begin
      req_a = (sa_q.size() > 0);
      {last_a, data_a} = req_a ? sa_q[0] : '0;
      req_b = (sb_q.size() > 0);
      {last_b, data_b} = req_b ? sb_q[0] : '0;
      out_ready = ($urandom_range(0, 3) != 0);
      smp();
      vectors++;
      if ((gnt_a && gnt_b) || (out_valid && !out_ready && (gnt_a || gnt_b))) begin
        miscompares++;
        $display("FAIL rnd_gnt cycle=%0d got=%0b%0b valid=%0b ready=%0b exp=no grant", cycles,
                 gnt_a, gnt_b, out_valid, out_ready);
      end
      if (out_valid && out_ready) begin
        src = out_data[DW-1];
        vectors++;
        if ((src ? exp_b_q.size() : exp_a_q.size()) == 0) begin
          miscompares++; $display("FAIL rnd_extra_word got=%h exp=none", out_data);
        end else begin
          w = src ? exp_b_q.pop_front() : exp_a_q.pop_front();
          run_k = (run_k != 0 && src == run_src) ? run_k + 1 : 1;
          run_src = src;
          exp_last = w[DW] || (run_k == MB);
          if (out_data !== w[DW-1:0] || out_last !== exp_last || (must_valid && src !== must_src)) begin
            miscompares++;
            $display("FAIL rnd_word got=%h/%0b exp=%h/%0b src_ok=%0b", out_data, out_last,
                     w[DW-1:0], exp_last, !(must_valid && src !== must_src));
          end
          must_valid = 1'b0;
          if (exp_last) begin
            run_k = 0;
            must_valid = src ? (sa_q.size() > 0) : (sb_q.size() > 0);
            must_src = !src;
          end
        end
      end
      if (gnt_a && sa_q.size() > 0) void'(sa_q.pop_front());
      if (gnt_b && sb_q.size() > 0) void'(sb_q.pop_front());
      done = (sa_q.size() == 0) && (sb_q.size() == 0) && !out_valid;
      cycles++;
      cyc();
    end
    vectors++;
    if (!done || exp_a_q.size() != 0 || exp_b_q.size() != 0) begin
      miscompares++;
      $display("FAIL rnd_complete got=done%0b left_a%0d left_b%0d exp=1/0/0", done,
               exp_a_q.size(), exp_b_q.size());
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    data_a = '0; data_b = '0;
    idle_inputs();
    test_reset();
    test_tie_limit();
    test_last_early();
    test_backpressure();
    test_truncation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
